seg7_scan_decoder: RTL

Recovers hex digits from a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and presents them as registered nibbles with per-digit valid and blank flags. It sits on the receiving side of the segment driver path. It is used for on-board self-test of the Tetris score display and for loopback checking in simulation. Inputs are treated as asynchronous, synchronized, and accepted only after a stability window.

---
 rtl/seg7_scan_decoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers hex digits from a scanned, active-low 7-segment bus (seg + an).
// Define SEG7DEC_DP_EN to also capture the decimal point (dp in, dps out).
module seg7_scan_decoder #(
  parameter int DIGITS = 4,
  parameter int STABLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg,
  input  logic [DIGITS-1:0]     an,
`ifdef SEG7DEC_DP_EN
  input  logic                  dp,
  output logic [DIGITS-1:0]     dps,
`endif
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     blank,
  output logic                  upd,
  output logic                  bad_pat,
  output logic                  bad_an
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [6:0]        seg_sy, cand_seg;
  logic [DIGITS-1:0] an_sy;
  logic [IW-1:0]     cand_idx, low_idx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [NW-1:0]     n_low;
  logic              multi_q, one_low, multi_low, same, commit;
  logic              hit, is_blank, changed;
  logic [3:0]        nib;
`ifdef SEG7DEC_DP_EN
  logic              dp_sy, cand_dp;
`endif

  always_comb begin
    n_low   = '0;
    low_idx = '0;
    for (int k = 0; k < DIGITS; k++)
      if (!an_sy[k]) begin
        n_low   = n_low + NW'(1);
        low_idx = IW'(k);
      end
    one_low   = (n_low == NW'(1));
    multi_low = (n_low > NW'(1));

    hit = 1'b0;
    nib = '0;
    for (int j = 0; j < 16; j++)
      if (seg_sy == SEG_TAB[j]) begin
        hit = 1'b1;
        nib = 4'(j);
      end
    is_blank = (seg_sy == 7'h7F);

    same = (low_idx == cand_idx) && (seg_sy == cand_seg);
`ifdef SEG7DEC_DP_EN
    same = same && (dp_sy == cand_dp);
`endif

    // Commit only on the cycle the count first reaches STABLE; saturation blocks re-commit.
    cnt_nx = cnt;
    commit = 1'b0;
    if (!one_low)
      cnt_nx = '0;
    else if (!same) begin
      cnt_nx = CW'(1);
      commit = (STABLE == 1);
    end else if (cnt != CNT_MAX) begin
      cnt_nx = cnt + CW'(1);
      commit = (cnt_nx == CNT_MAX);
    end

    changed = (hit && (nib != digits[4*int'(low_idx) +: 4])) ||
              (hit != valid[low_idx]) || (is_blank != blank[low_idx]);
`ifdef SEG7DEC_DP_EN
    changed = changed || (hit && (dps[low_idx] != ~dp_sy));
`endif
  end

  // The sync rank feeds the tracker, whose registers form the second rank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sy   <= '1;
      an_sy    <= '1;
      cand_idx <= '0;
      cand_seg <= '0;
      cnt      <= '0;
      multi_q  <= 1'b0;
      digits   <= '0;
      valid    <= '0;
      blank    <= '0;
      upd      <= 1'b0;
      bad_pat  <= 1'b0;
      bad_an   <= 1'b0;
`ifdef SEG7DEC_DP_EN
      dp_sy    <= 1'b1;
      cand_dp  <= 1'b0;
      dps      <= '0;
`endif
    end else begin
      seg_sy  <= seg;
      an_sy   <= an;
      cnt     <= cnt_nx;
      multi_q <= multi_low;
      bad_an  <= multi_low && !multi_q;
      upd     <= commit && changed;
      bad_pat <= commit && !hit && !is_blank;
      if (one_low && !same) begin
        cand_idx <= low_idx;
        cand_seg <= seg_sy;
      end
      if (commit) begin
        if (hit) digits[4*int'(low_idx) +: 4] <= nib;
        valid[low_idx] <= hit;
        blank[low_idx] <= is_blank;
      end
`ifdef SEG7DEC_DP_EN
      dp_sy <= dp;
      if (one_low && !same) cand_dp <= dp_sy;
      if (commit && hit) dps[low_idx] <= ~dp_sy;
`endif
    end
  end

endmodule
